// File: rtl/regfile_ctx_pkg.sv
// regfile_ctx_pkg: shared state encoding and constants for the context save/restore sequencer.
package regfile_ctx_pkg;
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} ctx_state_t;
    localparam logic [4:0] XZR_IDX   = 5'd31;
    localparam int         NREGS_DEF = 31;
endpackage

// File: rtl/ctx_idx_counter.sv
// ctx_idx_counter: 5-bit register index counter with clear, increment and terminal-count flag.
module ctx_idx_counter #(
    parameter logic [4:0] LAST = 5'd30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [4:0] o_idx,
    output logic       o_last
);
    logic [4:0] r_idx;
    always_ff @(posedge clk) begin
        if (reset || i_clr) r_idx <= '0;
        else if (i_inc) r_idx <= r_idx + 5'd1;
    end
    assign o_idx  = r_idx;
    assign o_last = r_idx == LAST;
endmodule

// File: rtl/regfile_ctx_seq.sv
// regfile_ctx_seq: walks X0..X30 out to a backing store on save and back into the regfile on restore.
// Define CTX_CHECKSUM_EN to accumulate a running XOR of transferred words on ctx_xor.
module regfile_ctx_seq
    import regfile_ctx_pkg::*;
#(
    parameter int N     = 64,
    parameter int NREGS = NREGS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         save_req,
    input  logic         restore_req,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [4:0]   rf_ra,
    input  logic [N-1:0] rf_rd,
    output logic         rf_we,
    output logic [4:0]   rf_wa,
    output logic [N-1:0] rf_wd,
    output logic         sv_valid,
    input  logic         sv_ready,
    output logic [4:0]   sv_idx,
    output logic [N-1:0] sv_data,
    input  logic         rs_valid,
    output logic         rs_ready,
    input  logic [N-1:0] rs_data,
    output logic [N-1:0] ctx_xor
);
    // Clamp so the walk can never reach XZR even if NREGS is oversized.
    localparam logic [4:0] LAST = (NREGS > 31) ? XZR_IDX - 5'd1 : 5'(NREGS - 1);

    ctx_state_t r_state;
    logic [4:0] w_idx;
    logic       w_last, w_start, w_sv_hs, w_rs_hs, w_hs;

    assign w_start = r_state == IDLE && (save_req || restore_req);
    assign w_sv_hs = r_state == SAVE && sv_ready;
    assign w_rs_hs = r_state == RESTORE && rs_valid && !reset;
    assign w_hs    = w_sv_hs || w_rs_hs;

    ctx_idx_counter #(.LAST(LAST)) u_idx (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start),
        .i_inc  (w_hs && !w_last),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else begin
            case (r_state)
                IDLE:          r_state <= save_req ? SAVE : restore_req ? RESTORE : IDLE;
                SAVE, RESTORE: r_state <= (w_hs && w_last) ? DONE : r_state;
                default:       r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_state != IDLE;
    assign stall    = busy;
    assign done     = r_state == DONE;
    assign sv_valid = r_state == SAVE;
    assign rs_ready = r_state == RESTORE;
    assign rf_ra    = sv_valid ? w_idx : '0;
    assign sv_idx   = sv_valid ? w_idx : '0;
    assign sv_data  = sv_valid ? rf_rd : '0;
    assign rf_we    = w_rs_hs;
    assign rf_wa    = w_rs_hs ? w_idx : '0;
    assign rf_wd    = w_rs_hs ? rs_data : '0;

`ifdef CTX_CHECKSUM_EN
    logic [N-1:0] r_xor;
    always_ff @(posedge clk) begin
        if (reset || w_start) r_xor <= '0;
        else if (w_hs) r_xor <= r_xor ^ (sv_valid ? rf_rd : rs_data);
    end
    assign ctx_xor = r_xor;
`else
    assign ctx_xor = '0;
`endif
endmodule
